// File: rtl/exc_commit_ctrl.sv
// ============================================================================
// exc_commit_ctrl
// ----------------------------------------------------------------------------
// Sequences exception and ertn commit at the write-back boundary of the
// 5-stage LoongArch pipeline.
//
// A commit-time exception or ertn seen in IDLE pulses the CSR file's commit
// strobes in the same cycle, latches the redirect target (EENTRY for an
// exception, ERA for ertn) and raises a pipeline-wide flush. The flush is held
// while outstanding inst/data bus transactions drain. Once the bus is quiet the
// target is offered to IF over a valid/ready handshake. The flush drops the
// cycle after that handshake fires.
//
// Optional feature macro:
//   EXC_BADV_EN  - when defined, ADE/ALE exceptions also write BADV
//                  (badv_we/badv_val). When undefined both are tied to 0.
//
// Parameters:
//   CNT_W           width of the outstanding-transaction counter
//                   (tracks at most 2**CNT_W-1 transactions, saturating)
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   wb_exc          WB instruction raises an exception (already ws_valid-qualified)
//   wb_ecode        exception code
//   wb_esubcode     exception subcode
//   wb_pc           PC of the excepting instruction
//   wb_badvaddr     faulting address
//   ertn_flush      WB ertn commits
//   csr_eentry      current EENTRY value
//   csr_era         current ERA value
//   bus_req_fire    inst/data bus request accepted this cycle
//   bus_resp_fire   inst/data bus response returned this cycle
//   flush           kill all IF..MEM stage contents
//   exc_commit      1-cycle strobe: CSR file writes ERA/ESTAT, saves PLV/IE
//   exc_ecode       ecode for the CSR write
//   exc_esubcode    subcode for the CSR write
//   exc_era         ERA value for the CSR write (= wb_pc)
//   badv_we         write BADV this cycle
//   badv_val        BADV value
//   ertn_commit     1-cycle strobe: CSR file restores PLV/IE
//   redirect_valid  redirect PC offered to IF
//   redirect_pc     redirect target
//   redirect_ready  IF accepts the redirect
// ============================================================================
module exc_commit_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        wb_exc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic        ertn_flush,

    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,

    input  logic        bus_req_fire,
    input  logic        bus_resp_fire,

    output logic        flush,
    output logic        exc_commit,
    output logic [5:0]  exc_ecode,
    output logic [8:0]  exc_esubcode,
    output logic [31:0] exc_era,
    output logic        badv_we,
    output logic [31:0] badv_val,
    output logic        ertn_commit,

    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] out_cnt_next;
    logic [31:0]      target;
    logic [31:0]      target_next;

    // A commit only counts in IDLE; the flush guarantees nothing new reaches
    // WB while a redirect is in flight. Reset masks it so no CSR strobe leaks
    // out during the reset cycle.
    logic trigger;
    assign trigger = (state == ST_IDLE) && !reset && (wb_exc || ertn_flush);

    // ------------------------------------------------------------------------
    // Outstanding bus transaction counter
    // ------------------------------------------------------------------------
    // Request and response in the same cycle cancel. Overflow and underflow
    // are protocol errors upstream; saturating keeps a stray pulse from
    // wrapping the count and stalling or short-cutting the drain.
    always_comb begin
        // NOTE: every combinational output is given a default before any
        // branch so no path leaves it unassigned and no latch is inferred.
        out_cnt_next = out_cnt;
        if (bus_req_fire && !bus_resp_fire) begin
            if (out_cnt != CNT_MAX) begin
                out_cnt_next = out_cnt + 1'b1;
            end
        end else if (!bus_req_fire && bus_resp_fire) begin
            if (out_cnt != CNT_ZERO) begin
                out_cnt_next = out_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        target_next    = target;
        flush          = 1'b0;
        exc_commit     = 1'b0;
        exc_ecode      = 6'd0;
        exc_esubcode   = 9'd0;
        exc_era        = 32'd0;
        ertn_commit    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        unique case (state)
            ST_IDLE: begin
                if (trigger) begin
                    flush      = 1'b1;
                    state_next = ST_DRAIN;
                    // Exception wins over a simultaneous ertn.
                    if (wb_exc) begin
                        exc_commit   = 1'b1;
                        exc_ecode    = wb_ecode;
                        exc_esubcode = wb_esubcode;
                        exc_era      = wb_pc;
                        target_next  = csr_eentry;
                    end else begin
                        ertn_commit  = 1'b1;
                        target_next  = csr_era;
                    end
                end
            end

            ST_DRAIN: begin
                flush = 1'b1;
                // Look at the post-update count so a response arriving this
                // cycle already lets us leave.
                if (out_cnt_next == CNT_ZERO) begin
                    state_next = ST_REDIRECT;
                end
            end

            ST_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target;
                if (redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its inputs from the same pre-edge values.
        if (reset) begin
            state   <= ST_IDLE;
            out_cnt <= '0;
            target  <= '0;
        end else begin
            state   <= state_next;
            out_cnt <= out_cnt_next;
            target  <= target_next;
        end
    end

    // ------------------------------------------------------------------------
    // BADV write
    // ------------------------------------------------------------------------
`ifdef EXC_BADV_EN
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [8:0] ESUB_ADEF  = 9'd0;

    always_comb begin
        badv_we  = 1'b0;
        badv_val = 32'd0;
        if (exc_commit && (wb_ecode == ECODE_ADE || wb_ecode == ECODE_ALE)) begin
            badv_we = 1'b1;
            // A fetch-address error faults on the PC itself; every other
            // address error reports the data address.
            if (wb_ecode == ECODE_ADE && wb_esubcode == ESUB_ADEF) begin
                badv_val = wb_pc;
            end else begin
                badv_val = wb_badvaddr;
            end
        end
    end
`else
    assign badv_we  = 1'b0;
    assign badv_val = 32'd0;

    // wb_badvaddr only feeds the BADV path; fold it into a sink so the
    // disabled build carries no dangling input.
    logic unused_badvaddr;
    assign unused_badvaddr = ^wb_badvaddr;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// ============================================================================
// tb_exc_commit_ctrl
// ----------------------------------------------------------------------------
// Directed bench for exc_commit_ctrl. A transaction-level model tracks the
// controller as "free / waiting for the bus to go quiet / offering a
// redirect" plus an outstanding-transaction count, and a compare process
// checks every DUT output against it at each falling edge. Directed scenarios
// add literal expectations at hand-computed cycles.
// ============================================================================
module tb_exc_commit_ctrl;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        reset;
    logic        wb_exc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        ertn_flush;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        bus_req_fire;
    logic        bus_resp_fire;
    logic        flush;
    logic        exc_commit;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;
    logic [31:0] exc_era;
    logic        badv_we;
    logic [31:0] badv_val;
    logic        ertn_commit;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    exc_commit_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_exc         (wb_exc),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_pc          (wb_pc),
        .wb_badvaddr    (wb_badvaddr),
        .ertn_flush     (ertn_flush),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
        .bus_req_fire   (bus_req_fire),
        .bus_resp_fire  (bus_resp_fire),
        .flush          (flush),
        .exc_commit     (exc_commit),
        .exc_ecode      (exc_ecode),
        .exc_esubcode   (exc_esubcode),
        .exc_era        (exc_era),
        .badv_we        (badv_we),
        .badv_val       (badv_val),
        .ertn_commit    (ertn_commit),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // phase 0: free to accept a commit
    // phase 1: commit taken, waiting for all bus transactions to return
    // phase 2: offering the redirect target
    // ------------------------------------------------------------------------
    int          m_phase;
    int          m_out;
    logic [31:0] m_target;
    bit          chk_en;

    function automatic int out_after(input int cur, input logic rq, input logic rs);
        int v;
        v = cur + int'(rq) - int'(rs);
        if (v > CNT_MAX) v = CNT_MAX;
        if (v < 0) v = 0;
        return v;
    endfunction

    function automatic logic [31:0] badv_expect(input logic [5:0] ec, input logic [8:0] sub,
                                                input logic [31:0] pc, input logic [31:0] va);
        return (ec == 6'h08 && sub == 9'd0) ? pc : va;
    endfunction

    initial begin
        m_phase  = 0;
        m_out    = 0;
        m_target = '0;
        chk_en   = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_phase  <= 0;
            m_out    <= 0;
            m_target <= '0;
        end else begin
            m_out <= out_after(m_out, bus_req_fire, bus_resp_fire);
            case (m_phase)
                0: if (wb_exc || ertn_flush) begin
                    m_phase  <= 1;
                    m_target <= wb_exc ? csr_eentry : csr_era;
                end
                1: if (out_after(m_out, bus_req_fire, bus_resp_fire) == 0) m_phase <= 2;
                2: if (redirect_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    // Compare process: all outputs, every cycle out of reset.
    always @(negedge clk) begin
        if (!reset && chk_en) begin
            check("m_flush", flush, (m_phase != 0) || wb_exc || ertn_flush);
            check("m_exc_commit", exc_commit, (m_phase == 0) && wb_exc);
            check("m_ertn_commit", ertn_commit, (m_phase == 0) && !wb_exc && ertn_flush);
            check("m_redirect_valid", redirect_valid, m_phase == 2);
            if (m_phase == 2) check("m_redirect_pc", redirect_pc, m_target);
            if (m_phase == 0 && wb_exc) begin
                check("m_exc_ecode", exc_ecode, wb_ecode);
                check("m_exc_esubcode", exc_esubcode, wb_esubcode);
                check("m_exc_era", exc_era, wb_pc);
            end
`ifdef EXC_BADV_EN
            begin
                logic exp_we;
                exp_we = (m_phase == 0) && wb_exc && (wb_ecode == 6'h08 || wb_ecode == 6'h09);
                check("m_badv_we", badv_we, exp_we);
                if (exp_we)
                    check("m_badv_val", badv_val,
                          badv_expect(wb_ecode, wb_esubcode, wb_pc, wb_badvaddr));
            end
`else
            check("m_badv_we", badv_we, 1'b0);
            check("m_badv_val", badv_val, 32'd0);
`endif
            // The pipeline flush means WB can never present a commit while
            // the controller is busy.
            if (m_phase != 0) check("m_no_trigger_while_busy", wb_exc | ertn_flush, 1'b0);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all start and end just after a rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_exc      = 1'b0;
        ertn_flush  = 1'b0;
        wb_ecode    = '0;
        wb_esubcode = '0;
        wb_pc       = '0;
        wb_badvaddr = '0;
    endtask

    // Hold redirect_ready high and wait (bounded) for the redirect to fire.
    task automatic wait_redirect(input string name, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        redirect_ready = 1'b1;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (redirect_valid) begin
                seen = 1'b1;
                check({name, "_pc"}, redirect_pc, exp_pc);
            end
            tick();
        end
        check({name, "_seen"}, seen, 1'b1);
        @(negedge clk);
        check({name, "_flush_low_after"}, flush, 1'b0);
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        reset          = 1'b1;
        bus_req_fire   = 1'b0;
        bus_resp_fire  = 1'b0;
        csr_eentry     = 32'h1C00_8000;
        csr_era        = 32'h1C00_0204;
        redirect_ready = 1'b1;
        clear_wb();
        repeat (3) tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_flush", flush, 1'b0);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_exc_commit", exc_commit, 1'b0);
        check("rst_ertn_commit", ertn_commit, 1'b0);
        check("rst_badv_we", badv_we, 1'b0);
        tick();

        // 1) Basic exception, no outstanding transactions
        wb_exc = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0100; csr_eentry = 32'h1C00_8000;
        @(negedge clk);                                     // N
        check("t1_exc_commit", exc_commit, 1'b1);
        check("t1_exc_era", exc_era, 32'h1C00_0100);
        check("t1_exc_ecode", exc_ecode, 6'h0B);
        check("t1_flush_n", flush, 1'b1);
        tick(); clear_wb();
        @(negedge clk);                                     // N+1
        check("t1_flush_n1", flush, 1'b1);
        check("t1_valid_n1", redirect_valid, 1'b0);
        check("t1_exc_commit_n1", exc_commit, 1'b0);
        tick();
        @(negedge clk);                                     // N+2
        check("t1_valid_n2", redirect_valid, 1'b1);
        check("t1_pc_n2", redirect_pc, 32'h1C00_8000);
        check("t1_flush_n2", flush, 1'b1);
        tick();
        @(negedge clk);                                     // N+3
        check("t1_flush_n3", flush, 1'b0);
        check("t1_valid_n3", redirect_valid, 1'b0);
        tick();

        // 2) ertn
        ertn_flush = 1'b1; csr_era = 32'h1C00_0204;
        @(negedge clk);
        check("t2_ertn_commit", ertn_commit, 1'b1);
        check("t2_exc_commit", exc_commit, 1'b0);
        tick(); clear_wb();
        tick();
        @(negedge clk);                                     // N+2
        check("t2_valid_n2", redirect_valid, 1'b1);
        check("t2_pc_n2", redirect_pc, 32'h1C00_0204);
        tick();

        // 3) Drain: two requests before N, responses at N+3 and N+5
        bus_req_fire = 1'b1;
        tick(); tick();
        bus_req_fire = 1'b0;
        wb_exc = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0300; csr_eentry = 32'h1C00_9000;
        for (int k = 0; k <= 6; k++) begin
            bus_resp_fire = (k == 3 || k == 5);
            @(negedge clk);
            check($sformatf("t3_valid_n%0d", k), redirect_valid, k == 6);
            check($sformatf("t3_flush_n%0d", k), flush, 1'b1);
            if (k == 6) check("t3_pc", redirect_pc, 32'h1C00_9000);
            tick();
            if (k == 0) clear_wb();
        end
        bus_resp_fire = 1'b0;
        @(negedge clk);                                     // N+7
        check("t3_flush_n7", flush, 1'b0);
        tick();

        // 4) Backpressure: ready low for the first 4 REDIRECT cycles
        redirect_ready = 1'b0;
        wb_exc = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0400; csr_eentry = 32'h1C00_A000;
        tick(); clear_wb();
        tick();                                             // N+2
        for (int k = 0; k < 5; k++) begin
            redirect_ready = (k == 4);
            @(negedge clk);
            check($sformatf("t4_valid_%0d", k), redirect_valid, 1'b1);
            check($sformatf("t4_pc_%0d", k), redirect_pc, 32'h1C00_A000);
            check($sformatf("t4_flush_%0d", k), flush, 1'b1);
            tick();
        end
        @(negedge clk);
        check("t4_flush_after", flush, 1'b0);
        check("t4_valid_after", redirect_valid, 1'b0);
        tick();
        redirect_ready = 1'b1;

        // 5) Simultaneous exception and ertn (ALE): exception wins
        wb_exc = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'd0;
        wb_pc = 32'h1C00_0500; wb_badvaddr = 32'h0000_0013;
        csr_eentry = 32'h1C00_B000; csr_era = 32'h1C00_0600;
        @(negedge clk);
        check("t5_exc_commit", exc_commit, 1'b1);
        check("t5_ertn_commit", ertn_commit, 1'b0);
`ifdef EXC_BADV_EN
        check("t5_badv_we", badv_we, 1'b1);
        check("t5_badv_val", badv_val, 32'h0000_0013);
`else
        check("t5_badv_we", badv_we, 1'b0);
`endif
        tick(); clear_wb();
        wait_redirect("t5_redirect", 32'h1C00_B000);

        // 6) ADEF: BADV takes the PC
        wb_exc = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'd0;
        wb_pc = 32'h1C00_0002; wb_badvaddr = 32'hDEAD_BEEF; csr_eentry = 32'h1C00_C000;
        @(negedge clk);
`ifdef EXC_BADV_EN
        check("t6_badv_we", badv_we, 1'b1);
        check("t6_badv_val", badv_val, 32'h1C00_0002);
`else
        check("t6_badv_val", badv_val, 32'd0);
`endif
        tick(); clear_wb();
        wait_redirect("t6_redirect", 32'h1C00_C000);

        // 7) Reset in DRAIN with three outstanding transactions
        bus_req_fire = 1'b1;
        repeat (3) tick();
        bus_req_fire = 1'b0;
        wb_exc = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0700; csr_eentry = 32'h1C00_D000;
        tick(); clear_wb();                                 // N+1, DRAIN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t7_flush_after_reset", flush, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t7_no_redirect_%0d", k), redirect_valid, 1'b0);
            tick();
        end
        // Counter must be 0: a fresh exception redirects at N+2.
        wb_exc = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0710; csr_eentry = 32'h1C00_E000;
        tick(); clear_wb();
        tick();
        @(negedge clk);
        check("t7_fresh_valid_n2", redirect_valid, 1'b1);
        tick();

        // 8) Saturation at max: 8 requests track as 7, so 7 responses drain it
        bus_req_fire = 1'b1;
        repeat (CNT_MAX + 1) tick();
        bus_req_fire = 1'b0;
        wb_exc = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0800; csr_eentry = 32'h1C00_F000;
        tick(); clear_wb();
        bus_resp_fire = 1'b1;
        repeat (CNT_MAX - 1) tick();
        @(negedge clk);
        check("t8_valid_before_last", redirect_valid, 1'b0);
        tick();
        bus_resp_fire = 1'b0;
        wait_redirect("t8_redirect", 32'h1C00_F000);

        // 9) Spurious response at zero must not wrap
        bus_resp_fire = 1'b1;
        tick();
        bus_resp_fire = 1'b0;
        wb_exc = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0900; csr_eentry = 32'h1C01_0000;
        tick(); clear_wb();
        tick();
        @(negedge clk);
        check("t9_valid_n2", redirect_valid, 1'b1);
        check("t9_pc_n2", redirect_pc, 32'h1C01_0000);
        tick();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
